// File: rtl/gamma_lut_ctrl.sv
// gamma_lut_ctrl: per-channel, double-buffered gamma lookup between the frame
// reader's VGA timing stream and the HDMI encoder. Bank swaps and bypass changes
// only take effect on a vsync leading edge. After reset an identity curve is
// written into both banks of every channel before host writes are accepted.
module gamma_lut_ctrl #(
   parameter int DW     = 8,
   parameter int CH     = 3,
   parameter bit VS_POL = 1'b1,
   localparam int CW    = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic            sclk,
   input  logic            s_rst,
   input  logic            i_vga_vsync,
   input  logic            i_vga_hsync,
   input  logic            i_vga_de,
   input  logic [CH*DW-1:0] i_vga_data,
   output logic            o_vga_vsync,
   output logic            o_vga_hsync,
   output logic            o_vga_de,
   output logic [CH*DW-1:0] o_vga_data,
   input  logic            cfg_we,
   input  logic [CW-1:0]   cfg_ch,
   input  logic [DW-1:0]   cfg_addr,
   input  logic [DW-1:0]   cfg_wdata,
   input  logic            cfg_swap,
   input  logic            cfg_bypass,
   output logic            o_cfg_ready,
   output logic            o_swap_pend,
   output logic            o_active_bank,
   output logic            o_bypass
);

   localparam int            DEPTH     = 1 << DW;
   localparam logic [DW-1:0] ADDR_LAST = {DW{1'b1}};
   localparam logic [DW-1:0] CNT_ONE   = {{(DW-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_r, state_s;
   logic [DW-1:0]   init_cnt_r;
   logic            vs_prev_r;
   logic            vs_act_s, vs_edge_s;
   logic            swap_apply_s;
   logic            swap_pend_r, pend_s;
   logic            active_bank_r, bank_s;
   logic            bypass_r, bypass_s;
   logic            cfg_ready_r;

   logic [CH-1:0]   wr_en0_s, wr_en1_s;
   logic [DW-1:0]   wr_addr_s, wr_data_s;

   logic [CH*DW-1:0] s1_pix_r;
   logic             s1_bank_r, s1_byp_r;
   logic             s1_vs_r, s1_hs_r, s1_de_r;
   logic [CH*DW-1:0] byp_data_r;
   logic             s2_byp_r;
   logic             s2_vs_r, s2_hs_r, s2_de_r;
   logic [CH*DW-1:0] lut_rd_s;

   assign vs_act_s  = (i_vga_vsync == VS_POL);
   assign vs_edge_s = vs_act_s & ~vs_prev_r;

   // Next state and table write port: identity fill in INIT, host shadow writes in RUN
   always_comb begin
      state_s   = state_r;
      wr_en0_s  = {CH{1'b0}};
      wr_en1_s  = {CH{1'b0}};
      wr_addr_s = init_cnt_r;
      wr_data_s = init_cnt_r;
      case (state_r)
         ST_INIT: begin
            wr_en0_s = {CH{1'b1}};
            wr_en1_s = {CH{1'b1}};
            if (init_cnt_r == ADDR_LAST) begin
               state_s = ST_RUN;
            end else begin
               state_s = ST_INIT;
            end
         end
         ST_RUN: begin
            wr_addr_s = cfg_addr;
            wr_data_s = cfg_wdata;
            // an out-of-range channel matches no slot, so the write is dropped
            for (int c = 0; c < CH; c++) begin
               if (cfg_we && (int'(cfg_ch) == c)) begin
                  wr_en0_s[c] = active_bank_r;
                  wr_en1_s[c] = ~active_bank_r;
               end else begin
                  wr_en0_s[c] = 1'b0;
                  wr_en1_s[c] = 1'b0;
               end
            end
         end
         default: begin
            state_s = ST_INIT;
         end
      endcase
   end

   // Frame-boundary control: swap request, bank toggle and bypass reload
   always_comb begin
      swap_apply_s = 1'b0;
      pend_s       = swap_pend_r;
      bank_s       = active_bank_r;
      bypass_s     = bypass_r;
      if (state_r == ST_RUN) begin
         swap_apply_s = vs_edge_s & (swap_pend_r | cfg_swap);
         if (swap_apply_s) begin
            bank_s = ~active_bank_r;
            pend_s = 1'b0;
         end else if (cfg_swap) begin
            pend_s = 1'b1;
         end else begin
            pend_s = swap_pend_r;
         end
         if (vs_edge_s) begin
            bypass_s = cfg_bypass;
         end else begin
            bypass_s = bypass_r;
         end
      end else begin
         bypass_s = 1'b1;
      end
   end

   // Control registers: FSM state, init counter, vsync history and status flags
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         state_r       <= ST_INIT;
         init_cnt_r    <= {DW{1'b0}};
         vs_prev_r     <= 1'b0;
         swap_pend_r   <= 1'b0;
         active_bank_r <= 1'b0;
         bypass_r      <= 1'b1;
         cfg_ready_r   <= 1'b0;
      end else begin
         state_r       <= state_s;
         init_cnt_r    <= (state_r == ST_INIT) ? init_cnt_r + CNT_ONE : init_cnt_r;
         vs_prev_r     <= vs_act_s;
         swap_pend_r   <= pend_s;
         active_bank_r <= bank_s;
         bypass_r      <= bypass_s;
         cfg_ready_r   <= (state_s == ST_RUN);
      end
   end

   // Pipeline: stage 1 captures pixel, read bank and bypass; stage 2 delays sync and bypass data
   always_ff @(posedge sclk) begin
      if (s_rst) begin
         s1_pix_r   <= {(CH*DW){1'b0}};
         s1_bank_r  <= 1'b0;
         s1_byp_r   <= 1'b1;
         s1_vs_r    <= 1'b0;
         s1_hs_r    <= 1'b0;
         s1_de_r    <= 1'b0;
         byp_data_r <= {(CH*DW){1'b0}};
         s2_byp_r   <= 1'b1;
         s2_vs_r    <= 1'b0;
         s2_hs_r    <= 1'b0;
         s2_de_r    <= 1'b0;
      end else begin
         s1_pix_r   <= i_vga_data;
         s1_bank_r  <= bank_s;
         s1_byp_r   <= bypass_r;
         s1_vs_r    <= i_vga_vsync;
         s1_hs_r    <= i_vga_hsync;
         s1_de_r    <= i_vga_de;
         byp_data_r <= s1_pix_r;
         s2_byp_r   <= s1_byp_r;
         s2_vs_r    <= s1_vs_r;
         s2_hs_r    <= s1_hs_r;
         s2_de_r    <= s1_de_r;
      end
   end

   for (genvar c = 0; c < CH; c++) begin : g_ch
      logic [DW-1:0] bank0_mem [DEPTH];
      logic [DW-1:0] bank1_mem [DEPTH];
      logic [DW-1:0] rd_r;

      // Table writes for this channel (both banks during init, shadow bank afterwards)
      always_ff @(posedge sclk) begin
         if (!s_rst && wr_en0_s[c]) begin
            bank0_mem[wr_addr_s] <= wr_data_s;
         end
         if (!s_rst && wr_en1_s[c]) begin
            bank1_mem[wr_addr_s] <= wr_data_s;
         end
      end

      // Synchronous table read for the pixel held in stage 1
      always_ff @(posedge sclk) begin
         if (s_rst) begin
            rd_r <= {DW{1'b0}};
         end else if (s1_bank_r) begin
            rd_r <= bank1_mem[s1_pix_r[c*DW +: DW]];
         end else begin
            rd_r <= bank0_mem[s1_pix_r[c*DW +: DW]];
         end
      end

      assign lut_rd_s[c*DW +: DW] = rd_r;
   end

   assign o_vga_data    = s2_byp_r ? byp_data_r : lut_rd_s;
   assign o_vga_vsync   = s2_vs_r;
   assign o_vga_hsync   = s2_hs_r;
   assign o_vga_de      = s2_de_r;
   assign o_cfg_ready   = cfg_ready_r;
   assign o_swap_pend   = swap_pend_r;
   assign o_active_bank = active_bank_r;
   assign o_bypass      = bypass_r;

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Bench for gamma_lut_ctrl: random video and configuration traffic checked every
// cycle against a table-level reference model (two banks of curves per channel).
module tb_gamma_lut_ctrl;

   localparam int DW = 8;
   localparam int CH = 3;
   localparam int PW = CH * DW;
   localparam int NE = 1 << DW;

   logic          sclk = 1'b0;
   logic          s_rst;
   logic          vsync, hsync, de;
   logic [PW-1:0] pix;
   logic          o_vsync, o_hsync, o_de;
   logic [PW-1:0] o_data;
   logic          cfg_we;
   logic [1:0]    cfg_ch;
   logic [DW-1:0] cfg_addr, cfg_wdata;
   logic          cfg_swap, cfg_bypass;
   logic          o_ready, o_pend, o_bank, o_byp;

   int n_cmp = 0;
   int n_bad = 0;

   // reference model state
   int            m_lut [2][CH][NE];
   int            m_cnt;
   bit            m_prev_vs, m_bank, m_pend, m_byp;
   logic [PW-1:0] r_pix;
   bit            r_bank, r_byp, r_vs, r_hs, r_de;
   logic [PW-1:0] e_data;
   bit            e_vs, e_hs, e_de;

   gamma_lut_ctrl #(.DW(DW), .CH(CH), .VS_POL(1'b1)) dut (
      .sclk          (sclk),
      .s_rst         (s_rst),
      .i_vga_vsync   (vsync),
      .i_vga_hsync   (hsync),
      .i_vga_de      (de),
      .i_vga_data    (pix),
      .o_vga_vsync   (o_vsync),
      .o_vga_hsync   (o_hsync),
      .o_vga_de      (o_de),
      .o_vga_data    (o_data),
      .cfg_we        (cfg_we),
      .cfg_ch        (cfg_ch),
      .cfg_addr      (cfg_addr),
      .cfg_wdata     (cfg_wdata),
      .cfg_swap      (cfg_swap),
      .cfg_bypass    (cfg_bypass),
      .o_cfg_ready   (o_ready),
      .o_swap_pend   (o_pend),
      .o_active_bank (o_bank),
      .o_bypass      (o_byp)
   );

   always #5 sclk = ~sclk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // advance the model by one clock using the inputs seen at that edge
   task automatic model_step();
      bit run, vedge, apply;
      if (s_rst) begin
         for (int b = 0; b < 2; b++)
            for (int c = 0; c < CH; c++)
               for (int a = 0; a < NE; a++)
                  m_lut[b][c][a] = a;
         m_cnt = 0; m_prev_vs = 1'b0; m_bank = 1'b0; m_pend = 1'b0; m_byp = 1'b1;
         r_pix = '0; r_bank = 1'b0; r_byp = 1'b1; r_vs = 1'b0; r_hs = 1'b0; r_de = 1'b0;
         e_data = '0; e_vs = 1'b0; e_hs = 1'b0; e_de = 1'b0;
      end else begin
         e_vs = r_vs; e_hs = r_hs; e_de = r_de;
         for (int c = 0; c < CH; c++)
            e_data[c*DW +: DW] = r_byp ? r_pix[c*DW +: DW] : DW'(m_lut[r_bank][c][r_pix[c*DW +: DW]]);
         run   = (m_cnt >= NE);
         vedge = vsync && !m_prev_vs;
         apply = run && vedge && (m_pend || cfg_swap);
         r_pix = pix; r_bank = apply ? !m_bank : m_bank; r_byp = m_byp;
         r_vs = vsync; r_hs = hsync; r_de = de;
         if (run && cfg_we && (int'(cfg_ch) < CH))
            m_lut[!m_bank][cfg_ch][cfg_addr] = int'(cfg_wdata);
         if (apply) begin
            m_bank = !m_bank;
            m_pend = 1'b0;
         end else if (run && cfg_swap) begin
            m_pend = 1'b1;
         end
         if (run && vedge) m_byp = cfg_bypass;
         if (!run) m_cnt++;
         m_prev_vs = vsync;
      end
   endtask

   task automatic tick();
      @(posedge sclk);
      model_step();
      @(negedge sclk);
      check("data",  32'(o_data),  32'(e_data));
      check("vsync", 32'(o_vsync), 32'(e_vs));
      check("hsync", 32'(o_hsync), 32'(e_hs));
      check("de",    32'(o_de),    32'(e_de));
      check("ready", 32'(o_ready), 32'(m_cnt >= NE));
      check("pend",  32'(o_pend),  32'(m_pend));
      check("bank",  32'(o_bank),  32'(m_bank));
      check("bypass",32'(o_byp),   32'(m_byp));
   endtask

   task automatic quiet();
      vsync = 1'b0; hsync = 1'b0; de = 1'b0; pix = PW'($urandom);
      cfg_we = 1'b0; cfg_swap = 1'b0;
   endtask

   // one frame: 3-cycle vsync, then 20-cycle lines; optional swap pulse, bypass change, random writes
   task automatic frame(input int len, input int we_pct, input int max_ch,
                        input int swap_at, input int byp_at, input bit byp_val);
      for (int i = 0; i < len; i++) begin
         vsync = (i < 3);
         hsync = ((i % 20) < 2);
         de    = !vsync && ((i % 20) >= 4);
         pix   = PW'($urandom);
         if ((i % 7) == 0) pix[DW-1:0] = 8'h10;
         cfg_we    = ($urandom_range(99) < we_pct);
         cfg_ch    = 2'($urandom_range(max_ch));
         cfg_addr  = 8'($urandom);
         cfg_wdata = 8'($urandom);
         cfg_swap  = (i == swap_at);
         if (i == byp_at) cfg_bypass = byp_val;
         tick();
      end
      quiet();
   endtask

   // write a whole curve into the shadow bank of every channel: 0 identity, 1 inverted, 2 random
   task automatic load_curve(input int kind);
      for (int c = 0; c < CH; c++) begin
         for (int a = 0; a < NE; a++) begin
            quiet();
            cfg_we   = 1'b1;
            cfg_ch   = 2'(c);
            cfg_addr = 8'(a);
            case (kind)
               0:       cfg_wdata = 8'(a);
               1:       cfg_wdata = 8'(255 - a);
               default: cfg_wdata = 8'($urandom);
            endcase
            tick();
         end
      end
      quiet();
   endtask

   task automatic swap_pulse();
      quiet();
      cfg_swap = 1'b1;
      tick();
      quiet();
      for (int i = 0; i < 3; i++) tick();
   endtask

   initial begin
      s_rst = 1'b1; cfg_bypass = 1'b0; cfg_ch = 2'd0; cfg_addr = 8'd0; cfg_wdata = 8'd0;
      quiet();
      for (int i = 0; i < 3; i++) tick();
      // release, run into INIT with traffic that must be ignored, then reset mid-init
      s_rst = 1'b0;
      frame(100, 50, 3, 5, 10, 1'b0);
      s_rst = 1'b1;
      tick(); tick();
      s_rst = 1'b0;
      // full init with writes/swaps/vsync edges that must all be ignored
      frame(NE + 4, 50, 3, 1, -1, 1'b0);
      // first frame in RUN applies bypass=0: identity curve
      cfg_bypass = 1'b0;
      frame(120, 0, 2, -1, -1, 1'b0);
      frame(120, 0, 2, -1, -1, 1'b0);
      // inverted curve via shadow load and pending swap
      load_curve(1);
      swap_pulse();
      frame(120, 0, 2, -1, -1, 1'b0);
      // swap requested in the vsync edge cycle itself
      load_curve(2);
      frame(120, 0, 2, 0, -1, 1'b0);
      // bypass changed mid-frame, applies only at the next frame
      frame(120, 0, 2, -1, 50, 1'b1);
      frame(120, 0, 2, -1, 60, 1'b0);
      frame(120, 0, 2, -1, -1, 1'b0);
      // invalid channel writes, random updates and swaps
      for (int f = 0; f < 8; f++) begin
         frame(150, 40, 3, (f % 3 == 2) ? -1 : int'($urandom_range(140)),
               (f % 4 == 3) ? 70 : -1, f[2]);
      end
      cfg_bypass = 1'b0;
      frame(120, 0, 3, -1, -1, 1'b0);
      // custom curve active, then reset mid-frame: identity must come back
      load_curve(1);
      swap_pulse();
      frame(60, 0, 2, -1, -1, 1'b0);
      vsync = 1'b0; hsync = 1'b1; de = 1'b1; pix = PW'($urandom);
      s_rst = 1'b1;
      tick(); tick();
      s_rst = 1'b0;
      frame(NE + 10, 30, 3, 20, -1, 1'b0);
      frame(120, 0, 2, -1, -1, 1'b0);
      frame(120, 0, 2, -1, -1, 1'b0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/gamma_lut_ctrl.md
# gamma_lut_ctrl

Parametrised, run-time programmable gamma correction stage for the HDMI output path, inserted between the DDR3 frame reader's VGA timing stream and the HDMI encoder. Each of CH colour channels passes through its own DW-bit lookup table held in double-buffered block RAM. The host rewrites the shadow bank while video runs, and bank swaps and bypass changes take effect only at a frame boundary (vsync leading edge). After reset an internal sequencer loads an identity curve into every table.

## Interface
- DW, 8, pixel width per channel; table depth 2^DW entries of DW bits
- CH, 3, number of colour channels (channel 0 in LSBs of packed buses)
- VS_POL, 1, active level of vsync (1 = active-high); "leading edge" means inactive->active
- CW, max(1,$clog2(CH)), derived: channel-select width (localparam)

- sclk  in  1  pixel clock, all logic on rising edge
- s_rst  in  1  synchronous reset, active-high
- i_vga_vsync  in  1  frame sync
- i_vga_hsync  in  1  line sync
- i_vga_de  in  1  data enable
- i_vga_data  in  CH*DW  packed pixel, channel c at [c*DW +: DW]
- o_vga_vsync  out  1  i_vga_vsync delayed 2 cycles
- o_vga_hsync  out  1  i_vga_hsync delayed 2 cycles
- o_vga_de  out  1  i_vga_de delayed 2 cycles
- o_vga_data  out  CH*DW  corrected (or bypassed) pixel, aligned with o_vga_de
- cfg_we  in  1  table write strobe, one entry per cycle
- cfg_ch  in  CW  target channel
- cfg_addr  in  DW  table index
- cfg_wdata  in  DW  table value
- cfg_swap  in  1  one-cycle request: make shadow bank active at next vsync leading edge
- cfg_bypass  in  1  requested bypass mode (level)
- o_cfg_ready  out  1  high when init done and cfg writes are accepted
- o_swap_pend  out  1  swap requested, not yet applied
- o_active_bank  out  1  bank currently read by the pixel path
- o_bypass  out  1  bypass mode currently applied

## Operation
- Storage: per channel, two banks of 2^DW x DW; pixel path reads bank o_active_bank, cfg writes go to bank ~o_active_bank only.
- FSM states: INIT, RUN.
  - Reset -> INIT; init counter = 0, o_active_bank = 0, o_swap_pend = 0, o_bypass = 1, o_cfg_ready = 0.
  - INIT: each cycle writes value = counter to address = counter in both banks of all channels; counter increments; after writing address 2^DW-1 -> RUN, o_cfg_ready = 1 from the next cycle. Duration exactly 2^DW cycles. o_bypass held 1 throughout; cfg_we, cfg_swap ignored.
  - RUN: o_bypass reloads from cfg_bypass at vsync leading edges only (first edge after entering RUN applies it).
- Writes: cfg_we accepted only in RUN; cfg_ch >= CH -> write dropped, no side effects. Back-to-back writes every cycle allowed.
- Swap: cfg_swap in RUN sets o_swap_pend. At vsync leading edge with o_swap_pend = 1 or cfg_swap = 1 in that same cycle: o_active_bank toggles, o_swap_pend clears. cfg_swap while already pending: no additional effect (one toggle only).
- Vsync leading edge detected from registered i_vga_vsync vs current input (edge cycle = first cycle input is active).
- Bypass: o_vga_data = input delayed 2 cycles; table read result discarded.
- Data path: stage 1 registers input/address; stage 2 is the synchronous RAM read register (or the bypass delay register); output mux selects by o_bypass sampled at stage 1.
- Write and read of the same address in the same cycle cannot conflict (different banks).

## Timing
- Latency: fixed 2 cycles input->output for data, vsync, hsync, de, in both modes.
- Reset values: o_vga_vsync/hsync/de = 0, o_vga_data = 0 (for 2 cycles after reset, then pipeline contents), o_cfg_ready = 0, o_swap_pend = 0, o_active_bank = 0, o_bypass = 1.
- Bank toggle at edge cycle E: pixels entering at E onward use the new bank; pixel at E-1 uses the old bank.
- o_swap_pend rises the cycle after cfg_swap; falls the cycle after E.
- Reset asserted mid-frame or mid-init: all state returns to reset values; INIT restarts from address 0; previous table contents are overwritten.

## Test plan
- Reset, hold 2^DW+4 cycles (DW=8): o_cfg_ready rises at cycle 256 after reset release; feed ramp 0..255 with bypass=0 after first vsync -> output equals input, 2-cycle delay.
- Load inverted curve (addr a -> 255-a) into shadow, cfg_swap, then vsync edge: pixels in that frame output 255-x; pixel 0x10 -> 0xEF; o_swap_pend 1->0 at edge.
- cfg_swap asserted in the exact vsync edge cycle with o_swap_pend=0 -> bank toggles that cycle, o_swap_pend stays 0.
- cfg_bypass=1 mid-frame -> output stays table-mapped until next vsync edge, then equals delayed input.
- cfg_we with cfg_ch=3 (CH=3), and cfg_we during INIT -> no table change, verified by readback through swap.
- Assert s_rst during a frame after loading a custom curve -> outputs zero, o_active_bank=0, identity curve restored after 256 cycles.
